// File: rtl/branch_pkg.sv
// Shared definitions for branch resolution: opcodes, condition codes,
// handshake FSM states and the registered result record.
package branch_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_cond_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } br_state_e;

  // redir_pc is XLEN_DEF wide; the top's XLEN must equal XLEN_DEF.
  typedef struct packed {
    logic                taken;
    logic                mispred;
    logic                illegal;
    logic [XLEN_DEF-1:0] redir_pc;
  } br_result_t;

  function automatic logic is_ctrl_op(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/branch_resolve_cond_eval.sv
// Branch condition decode: funct3 plus comparator flags -> taken/illegal.
module br_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       br_eq,
  input  logic       br_lt,
  input  logic       br_ltu,
  output logic       taken,
  output logic       illegal
);

  // Select the comparator flag (or its inverse) named by funct3
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (br_cond_e'(funct3))
      BEQ:     taken = br_eq;
      BNE:     taken = !br_eq;
      BLT:     taken = br_lt;
      BGE:     taken = !br_lt;
      BLTU:    taken = br_ltu;
      BGEU:    taken = !br_ltu;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch/jump resolution stage: decodes the condition, computes the target,
// checks it against the fetch prediction and holds one result for fetch
// behind a valid/ready handshake.
// Optional macro BR_PERF_CNT_EN adds saturating branch/mispredict counters.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF
`ifdef BR_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            br_eq,
  input  logic            br_lt,
  input  logic            br_ltu,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            pred_taken,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic            mispred,
  output logic [XLEN-1:0] redir_pc,
  output logic            illegal
`ifdef BR_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt
`endif
);

  br_state_e  state_q, state_d;
  br_result_t res_q, res_d;
  logic       load;
  logic       accept;
  logic       cond_taken, cond_illegal;

  logic [XLEN-1:0] pc_seq, br_tgt, jalr_sum, jalr_tgt;

  br_cond_eval u_cond (
    .funct3  (funct3),
    .br_eq   (br_eq),
    .br_lt   (br_lt),
    .br_ltu  (br_ltu),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  assign pc_seq   = pc + XLEN'(4);
  assign br_tgt   = pc + imm;
  assign jalr_sum = rs1 + imm;
  assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};

  // Handshake state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next state and result-load enable; flush wins over any accept/consume
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = FULL;
            load    = 1'b1;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (accept) load = 1'b1;
            else        state_d = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Resolve outcome and redirect target for the presented instruction
  always_comb begin
    res_d         = '0;
    res_d.illegal = 1'b0;
    case (opcode)
      OP_BRANCH: begin
        res_d.taken    = cond_taken && !cond_illegal;
        res_d.illegal  = cond_illegal;
        res_d.redir_pc = res_d.taken ? br_tgt : pc_seq;
      end
      OP_JAL: begin
        res_d.taken    = 1'b1;
        res_d.redir_pc = br_tgt;
      end
      OP_JALR: begin
        res_d.taken    = 1'b1;
        res_d.redir_pc = jalr_tgt;
      end
      default: begin
        res_d.taken    = 1'b0;
        res_d.redir_pc = pc_seq;
      end
    endcase
    res_d.mispred = res_d.taken != pred_taken;
  end

  // Result register, only written on an accepted input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    res_q <= '0;
    else if (load) res_q <= res_d;
  end

  assign taken    = res_q.taken;
  assign mispred  = res_q.mispred;
  assign illegal  = res_q.illegal;
  assign redir_pc = res_q.redir_pc;

`ifdef BR_PERF_CNT_EN
  logic is_ctrl_q;
  logic consume;

  assign consume = out_valid && out_ready && !flush && is_ctrl_q;

  // Saturating counters for consumed branch/jump results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_ctrl_q   <= 1'b0;
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else begin
      if (load) is_ctrl_q <= is_ctrl_op(opcode);
      if (consume) begin
        if (br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
        if (res_q.mispred && (mispred_cnt != '1))
          mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
